// File: rtl/aes_sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes engine: LANES shared S-box lookups per cycle over a BYTES-wide state.
// Optional macro SBOX_PIPE_EN inserts a register stage between lookup and write-back (adds a PIPE state).
module aes_sub_bytes_engine #(
   parameter int BYTES = 16,
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_inv,
   input  logic [8*BYTES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*BYTES-1:0] out_data,
   output logic               busy
);

   localparam int N_CHUNKS = BYTES / LANES;
   localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
`ifdef SBOX_PIPE_EN
   localparam logic [1:0] S_PIPE = 2'd2;
`endif
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [0:255][7:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)
          || (BYTES % LANES) != 0) begin : g_bad_lanes
         $error("aes_sub_bytes_engine: LANES must be 1,2,4,8 or 16 and divide BYTES");
      end
   endgenerate

   // Working word viewed as chunks of LANES bytes; chunk k holds bytes k*LANES .. k*LANES+LANES-1.
   logic [N_CHUNKS-1:0][LANES-1:0][7:0] work_q, work_d;
   logic [8*BYTES-1:0]                  out_q, out_d;
   logic [CW-1:0]                       cnt_q, cnt_d;
   logic                                inv_q, inv_d;
   logic [1:0]                          state_q, state_d;
   logic [LANES-1:0][7:0]               lk_in, lk_out;
   logic                                last_chunk;

`ifdef SBOX_PIPE_EN
   logic [LANES-1:0][7:0] pipe_q, pipe_d;
   logic [CW-1:0]         pipe_idx_q, pipe_idx_d;
   logic                  pipe_vld_q, pipe_vld_d;
`endif

   assign lk_in      = work_q[cnt_q];
   assign last_chunk = (cnt_q == CW'(N_CHUNKS - 1));

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lk_out[gi] = inv_q ? SBOX_INV[lk_in[gi]] : SBOX_FWD[lk_in[gi]];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      work_d  = work_q;
      out_d   = out_q;
`ifdef SBOX_PIPE_EN
      pipe_d     = pipe_q;
      pipe_idx_d = pipe_idx_q;
      pipe_vld_d = 1'b0;
      // The lookup issued last cycle lands now; it never targets the chunk being read.
      if (pipe_vld_q) begin
         work_d[pipe_idx_q] = pipe_q;
      end
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               inv_d   = in_inv;
               work_d  = in_data;
            end
         end
         S_BUSY: begin
`ifdef SBOX_PIPE_EN
            pipe_d     = lk_out;
            pipe_idx_d = cnt_q;
            pipe_vld_d = 1'b1;
`else
            work_d[cnt_q] = lk_out;
`endif
            if (last_chunk) begin
               cnt_d = '0;
`ifdef SBOX_PIPE_EN
               state_d = S_PIPE;
`else
               state_d = S_DONE;
               out_d   = work_d;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef SBOX_PIPE_EN
         S_PIPE: begin
            state_d = S_DONE;
            out_d   = work_d;
         end
`endif
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
         work_q  <= '0;
         out_q   <= '0;
`ifdef SBOX_PIPE_EN
         pipe_q     <= '0;
         pipe_idx_q <= '0;
         pipe_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
         work_q  <= work_d;
         out_q   <= out_d;
`ifdef SBOX_PIPE_EN
         pipe_q     <= pipe_d;
         pipe_idx_q <= pipe_idx_d;
         pipe_vld_q <= pipe_vld_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_q;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Directed self-checking bench for aes_sub_bytes_engine (BYTES=16, LANES=4); honours SBOX_PIPE_EN for latency.
module tb_aes_sub_bytes_engine;

`ifdef SBOX_PIPE_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   localparam logic [127:0] ZEROS    = 128'h0;
   localparam logic [127:0] ALL_63   = {16{8'h63}};
   localparam logic [127:0] ALL_53   = {16{8'h53}};
   localparam logic [127:0] ALL_ED   = {16{8'hed}};
   localparam logic [127:0] INV_IN   = 128'h16ed630016ed630016ed630016ed6300;
   localparam logic [127:0] INV_OUT  = 128'hff530052ff530052ff530052ff530052;
   localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   aes_sub_bytes_engine #(.BYTES(16), .LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int start, output int n);
      n = start;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   // Present one word, check the accept-to-out_valid latency, consume the result.
   task automatic run_word(input string tag, input logic [127:0] d, input logic inv,
                           output logic [127:0] res);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      tick();
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_inv   = ~inv;
      wait_out(0, n);
      chk({tag, "_latency"}, 128'(n), 128'(LAT));
      res       = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] res;
      logic [127:0] x;
      logic [127:0] y;
      int           n;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_inv    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_data", out_data, ZEROS);
      chk("rst_busy", 128'(busy), 128'(1'b0));
      rst_n = 1'b1;
      tick();

      run_word("fwd_zero", ZEROS, 1'b0, res);
      chk("fwd_zero_data", res, ALL_63);
      run_word("inv_pattern", INV_IN, 1'b1, res);
      chk("inv_pattern_data", res, INV_OUT);
      run_word("fips_fwd", FIPS_IN, 1'b0, res);
      chk("fips_fwd_data", res, FIPS_OUT);
      run_word("fips_inv", FIPS_OUT, 1'b1, res);
      chk("fips_inv_data", res, FIPS_IN);
      chk("held_after_consume", out_data, FIPS_IN);

      for (int i = 0; i < 1000; i++) begin
         x = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_word("rt_fwd", x, 1'b0, y);
         run_word("rt_inv", y, 1'b1, res);
         chk("round_trip", res, x);
      end

      // Backpressure: hold the result in DONE while in_valid pulses are offered.
      in_valid = 1'b1;
      in_data  = FIPS_IN;
      in_inv   = 1'b0;
      tick();
      in_valid = 1'b0;
      wait_out(0, n);
      chk("bp_latency", 128'(n), 128'(LAT));
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_inv   = i[1];
         chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
         chk("bp_out_data", out_data, FIPS_OUT);
         chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
         tick();
      end
      in_valid  = 1'b1;
      in_data   = ALL_53;
      in_inv    = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));
      chk("bp_release_out_valid", 128'(out_valid), 128'(1'b0));
      chk("bp_release_busy", 128'(busy), 128'(1'b0));
      chk("bp_release_held", out_data, FIPS_OUT);
      tick();
      in_valid = 1'b0;
      chk("bp_next_busy", 128'(busy), 128'(1'b1));
      wait_out(0, n);
      chk("bp_next_latency", 128'(n), 128'(LAT));
      chk("bp_next_data", out_data, ALL_ED);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Abort: reset while BUSY with counter at 2.
      in_valid = 1'b1;
      in_data  = FIPS_IN;
      in_inv   = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_in_ready", 128'(in_ready), 128'(1'b1));
      chk("abort_out_valid", 128'(out_valid), 128'(1'b0));
      chk("abort_out_data", out_data, ZEROS);
      chk("abort_busy", 128'(busy), 128'(1'b0));
      run_word("post_abort", ZEROS, 1'b0, res);
      chk("post_abort_data", res, ALL_63);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
